// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg: state encodings and frame constants shared by UART TX/RX. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_WIDTH   = 8;
  // start + data + stop
  localparam int FRAME_BITS           = 10;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//------------------------------------------------------------------------------
// uart_baud_counter: per-bit cycle counter with terminal-count pulse. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tc = en && (count == LAST);

  // clear takes priority so a new state always starts from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
//------------------------------------------------------------------------------
// uart_tx_drain: pops bytes from the FIFO and shifts them out as 8N1. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tx_reg;
  logic                  tx_next;
  logic                  baud_en;
  logic                  baud_tc;
  logic                  baud_clear;

  assign baud_en    = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
  assign baud_clear = (state_next != state);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .en   (baud_en),
    .tc   (baud_tc)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (tx_en && !fifo_empty) state_next = ST_POP;
      ST_POP:   state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_START;
      ST_START: if (baud_tc) state_next = ST_DATA;
      ST_DATA:  if (baud_tc && (bit_idx == LAST_IDX)) state_next = ST_STOP;
      ST_STOP:  if (baud_tc) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // tx is decoded from the next state so the pin itself is a plain register;
  // on a data-bit boundary the register shifts on the same edge, hence bit 1
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = ((state == ST_DATA) && baud_tc) ? shift_reg[1] : shift_reg[0];
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state  <= state_next;
      tx_reg <= tx_next;
      // fifo_dout is only meaningful the cycle after the pop
      if (state == ST_LOAD) begin
        shift_reg <= fifo_dout;
        bit_idx   <= '0;
      end else if ((state == ST_DATA) && baud_tc) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 1'b1;
      end
    end
  end

  assign tx       = tx_reg;
  assign fifo_pop = (state == ST_POP);
  assign busy     = (state != ST_IDLE);
  assign tx_done  = (state == ST_STOP) && baud_tc;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
//------------------------------------------------------------------------------
// tb_uart_tx_drain: FIFO model, frame decoder and scoreboard for uart_tx_drain.
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts[$];

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int aborts = 0;
  int frames = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  // FIFO model: registered read data, zero when not popped, empty flag lags the pop edge
  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      else fifo_dout <= 8'h00;
    end else begin
      fifo_dout <= 8'h00;
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (tx_done) done_cnt <= done_cnt + 1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (fifo_pop && fifo_empty) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame decoder: every cycle of a frame is compared with the ideal 8N1 waveform
  initial begin : monitor
    int         errs;
    logic [7:0] got;
    logic [7:0] eb;
    logic       exp_lvl;
    bit         aborted;
    int         b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        errs    = 0;
        got     = 8'h00;
        aborted = 1'b0;
        if (exp_q.size() > 0) begin
          eb = exp_q[0];
        end else begin
          eb = 8'h00;
          errs++;
        end
        for (int c = 0; c < FRAME_CYC; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          b = c / CPB;
          if (b == 0) exp_lvl = 1'b0;
          else if (b <= 8) exp_lvl = eb[b-1];
          else exp_lvl = 1'b1;
          if (tx !== exp_lvl) errs++;
          if (b >= 1 && b <= 8 && (c % CPB) == CPB / 2) got[b-1] = tx;
          if (busy !== 1'b1) errs++;
          if (tx_done !== (c == FRAME_CYC - 1)) errs++;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (aborted) begin
          aborts++;
        end else begin
          frames++;
          check("frame_byte", 32'(got), 32'(eb));
          check("frame_shape", errs, 0);
        end
      end
    end
  end

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    step(1);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin : stim
    int p0, d0, f0, s0, a0;

    // reset held with a byte waiting
    tx_en = 1'b1;
    push(8'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
    end
    p0 = pop_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain("first", 200);
    check("first_pops", pop_cnt - p0, 1);

    // single byte 0xA5
    p0 = pop_cnt; d0 = done_cnt; f0 = frames;
    push(8'hA5);
    drain("a5", 200);
    check("a5_pops", pop_cnt - p0, 1);
    check("a5_done", done_cnt - d0, 1);
    check("a5_frames", frames - f0, 1);

    // three bytes back to back
    p0 = pop_cnt; s0 = starts.size();
    push(8'h00); push(8'hFF); push(8'h3C);
    drain("three", 400);
    step(10);
    check("three_pops", pop_cnt - p0, 3);
    check("three_gap01", starts[s0+1] - starts[s0], FRAME_CYC + 3);
    check("three_gap12", starts[s0+2] - starts[s0+1], FRAME_CYC + 3);
    check("three_empty", 32'(fifo_empty), 32'd1);

    // tx_en gating and pop latency
    tx_en = 1'b0;
    p0 = pop_cnt;
    push(8'h3A);
    step(10);
    check("en0_pops", pop_cnt - p0, 0);
    check("en0_tx", 32'(tx), 32'd1);
    check("en0_busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    @(negedge clk); check("lat_pop0", 32'(fifo_pop), 32'd0);
    @(negedge clk); check("lat_pop1", 32'(fifo_pop), 32'd1);
    @(negedge clk); check("lat_pop2", 32'(fifo_pop), 32'd0);
    check("lat_tx_load", 32'(tx), 32'd1);
    @(negedge clk); check("lat_tx_start", 32'(tx), 32'd0);
    step(5);
    push(8'h5C);
    tx_en = 1'b0;
    begin
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("en_drop_timeout", 32'(n < 100), 32'd1);
    end
    step(12);
    check("en_drop_pops", pop_cnt - p0, 1);
    check("en_drop_left", fifo_q.size(), 1);
    check("en_drop_tx", 32'(tx), 32'd1);
    tx_en = 1'b1;
    drain("en_resume", 200);
    check("en_resume_pops", pop_cnt - p0, 2);

    // reset during bit 4 of 0x96; next byte must still go out intact
    a0 = aborts; f0 = frames;
    push(8'h96); push(8'h5A);
    wait_tx_low("mid_start", 100);
    repeat (19) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pop", 32'(fifo_pop), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain("mid_after", 200);
    check("mid_aborts", aborts - a0, 1);
    check("mid_frames", frames - f0, 1);

    // exactly one byte presented
    p0 = pop_cnt;
    push(8'hC3);
    drain("one", 200);
    step(20);
    check("one_pops", pop_cnt - p0, 1);

    // randomized bytes with random arrival gaps
    p0 = pop_cnt; d0 = done_cnt; f0 = frames;
    for (int i = 0; i < 20; i++) begin
      push(8'($urandom_range(0, 255)));
      step($urandom_range(0, 60));
    end
    drain("rand", 4000);
    step(10);
    check("rand_pops", pop_cnt - p0, 20);
    check("rand_done", done_cnt - d0, 20);
    check("rand_frames", frames - f0, 20);

    check("no_pop_when_empty", viol, 0);
    check("exp_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
